// File: rtl/xor_frame_checksum_pkg.sv
// Shared encodings for the frame checksum engine.
// State and mode constants used by the top and the bench.
package xor_frame_checksum_pkg;

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   localparam logic MODE_XOR  = 1'b0;
   localparam logic MODE_XNOR = 1'b1;

endpackage

// File: rtl/xor_frame_checksum_nor_xor_bit.sv
// Single-bit XOR cell built purely from two-input NOR gates.
// Inverters, cross terms, XNOR, then a final inverter.
module nor_xor_bit (
   input  logic a,
   input  logic b,
   output logic y
);

   logic na;
   logic nb;
   logic a_nb;
   logic na_b;
   logic xn;

   assign na   = ~(a | a);
   assign nb   = ~(b | b);
   // a & ~b and ~a & b expressed as NORs of the complements
   assign a_nb = ~(na | b);
   assign na_b = ~(a | nb);
   assign xn   = ~(a_nb | na_b);
   assign y    = ~(xn | xn);

endmodule

// File: rtl/xor_frame_checksum.sv
// Frame-based XOR/XNOR checksum accumulator with valid/ready
// handshakes on both the word input and the checksum output.
module xor_frame_checksum
   import xor_frame_checksum_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_parity,
   output logic [7:0]       frame_count
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [0:0]       state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] sum;
   logic [CNT_W-1:0] word_cnt;
   logic             mode_q;
   logic             eff_mode;
   logic             accept;
   logic             first;
   logic             last;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign first     = (word_cnt == '0);
   assign last      = (word_cnt == CNT_W'(FRAME_LEN - 1));

   // The first word's mode applies; this also covers single-word frames.
   assign eff_mode  = first ? mode : mode_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_xor
      nor_xor_bit u_bit (
         .a (acc[i]),
         .b (in_data[i]),
         .y (acc_nxt[i])
      );
   end

   assign sum = acc_nxt ^ {WIDTH{eff_mode == MODE_XNOR}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ACCUM;
         acc         <= '0;
         word_cnt    <= '0;
         mode_q      <= MODE_XOR;
         out_sum     <= '0;
         out_parity  <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         unique case (state)
            ACCUM: begin
               if (accept) begin
                  acc <= acc_nxt;
                  if (first) mode_q <= mode;
                  if (last) begin
                     out_sum    <= sum;
                     out_parity <= ^sum;
                     word_cnt   <= '0;
                     state      <= HOLD;
                  end else begin
                     word_cnt <= word_cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc         <= '0;
                  frame_count <= frame_count + 8'd1;
                  state       <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Directed bench: table of frames, backpressure, reset,
// frame_count wrap and a 1-bit truth table on a second instance.
module tb_xor_frame_checksum;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       mode = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_sum;
   logic       out_parity;
   logic [7:0] frame_count;

   logic       b_in_valid = 1'b0;
   logic       b_in_ready;
   logic [0:0] b_in_data = 1'b0;
   logic       b_mode = 1'b0;
   logic       b_out_valid;
   logic       b_out_ready = 1'b0;
   logic [0:0] b_out_sum;
   logic       b_out_parity;
   logic [7:0] b_frame_count;

   int errors = 0;
   int checks = 0;
   int fc = 0;

   always #5 clk = ~clk;

   xor_frame_checksum #(.WIDTH(8), .FRAME_LEN(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .mode        (mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_parity  (out_parity),
      .frame_count (frame_count)
   );

   xor_frame_checksum #(.WIDTH(1), .FRAME_LEN(2)) dut_w1 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (b_in_valid),
      .in_ready    (b_in_ready),
      .in_data     (b_in_data),
      .mode        (b_mode),
      .out_valid   (b_out_valid),
      .out_ready   (b_out_ready),
      .out_sum     (b_out_sum),
      .out_parity  (b_out_parity),
      .frame_count (b_frame_count)
   );

   typedef struct packed {
      logic [31:0] words;
      logic [3:0]  modes;
      logic [7:0]  sum;
      logic        par;
   } vec_t;

   typedef struct packed {
      logic x;
      logic y;
      logic m;
      logic s;
   } bvec_t;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Entered and left on a negedge; the word is taken at the posedge between.
   task automatic push(input logic [7:0] d, input logic m);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      mode     = m;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("push_timeout", 32'd1, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pop(input string name, input logic [7:0] s,
                      input logic p);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check({name, "_timeout"}, 32'd1, 32'd0);
      check({name, "_sum"}, 32'(out_sum), 32'(s));
      check({name, "_par"}, 32'(out_parity), 32'(p));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      fc = (fc + 1) % 256;
      check({name, "_fcnt"}, 32'(frame_count), 32'(fc));
      check({name, "_rdy"}, 32'(in_ready), 32'd1);
   endtask

   vec_t  tbl  [6];
   bvec_t btbl [8];

   initial begin
      tbl[0] = '{32'h08040201, 4'b0000, 8'h0F, 1'b0};
      tbl[1] = '{32'h08040201, 4'b0011, 8'hF0, 1'b0};
      tbl[2] = '{32'h00FF5AA5, 4'b0000, 8'h00, 1'b0};
      tbl[3] = '{32'h00000080, 4'b0000, 8'h80, 1'b1};
      tbl[4] = '{32'h00000080, 4'b1111, 8'h7F, 1'b1};
      tbl[5] = '{32'h78563412, 4'b1110, 8'h08, 1'b1};

      btbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      btbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
      btbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
      btbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0};
      btbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      btbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
      btbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
      btbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

      repeat (2) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(out_sum), 32'd0);
      check("rst_par", 32'(out_parity), 32'd0);
      check("rst_fcnt", 32'(frame_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 6; i++) begin
         for (int w = 0; w < 4; w++)
            push(tbl[i].words[8*w +: 8], tbl[i].modes[w]);
         check($sformatf("v%0d_lat", i), 32'(out_valid), 32'd1);
         check($sformatf("v%0d_busy", i), 32'(in_ready), 32'd0);
         pop($sformatf("v%0d", i), tbl[i].sum, tbl[i].par);
      end

      // Backpressure: 0x55 waits in HOLD and becomes word 0 of the next frame.
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h44, 1'b0);
      push(8'h88, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h55;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_ready", 32'(in_ready), 32'd0);
         check("bp_sum", 32'(out_sum), 32'hFF);
      end
      pop("bp", 8'hFF, 1'b0);
      push(8'h55, 1'b0);
      push(8'h00, 1'b0);
      push(8'h00, 1'b0);
      push(8'h01, 1'b0);
      pop("bp_next", 8'h54, 1'b1);

      // Reset mid-frame discards the partial accumulation.
      push(8'hFF, 1'b0);
      push(8'h0F, 1'b0);
      reset = 1'b1;
      #1;
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_fcnt", 32'(frame_count), 32'd0);
      fc = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      push(8'hA5, 1'b0);
      push(8'hA5, 1'b0);
      push(8'h3C, 1'b0);
      check("mr_early", 32'(out_valid), 32'd0);
      push(8'h00, 1'b0);
      pop("mr", 8'h3C, 1'b0);

      // 257 all-zero frames with gaps between words.
      for (int f = 0; f < 257; f++) begin
         for (int w = 0; w < 4; w++) begin
            push(8'h00, 1'b0);
            if (w[0]) @(negedge clk);
         end
         pop("wrap", 8'h00, 1'b0);
      end
      check("wrap_final", 32'(frame_count), 32'd2);

      // WIDTH=1, FRAME_LEN=2 truth table.
      for (int i = 0; i < 8; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = btbl[i].x;
         b_mode     = btbl[i].m;
         @(negedge clk);
         b_in_data  = btbl[i].y;
         @(negedge clk);
         b_in_valid = 1'b0;
         check($sformatf("w1_%0d_valid", i), 32'(b_out_valid), 32'd1);
         check($sformatf("w1_%0d_sum", i), 32'(b_out_sum), 32'(btbl[i].s));
         check($sformatf("w1_%0d_par", i), 32'(b_out_parity),
               32'(btbl[i].s));
         b_out_ready = 1'b1;
         @(negedge clk);
         b_out_ready = 1'b0;
      end
      check("w1_fcnt", 32'(b_frame_count), 32'd8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xor_frame_checksum.md
Name: xor_frame_checksum

Overview:
Streaming XOR checksum engine built on the team's NOR-only XOR cell.
- Accepts WIDTH-bit words over a valid/ready input, folds FRAME_LEN words into a bitwise XOR (or XNOR) checksum, and presents the result on a valid/ready output.
- Sits between a word source and a checker or logger.
- Replaces per-pair combinational XOR with a parametrised, frame-based, back-pressured accumulator.

Parameters:
- WIDTH, 8, data and checksum width in bits (>=1).
- FRAME_LEN, 4, words per frame (>=1).
- CNT_W, derived as clog2(FRAME_LEN) with a minimum of 1; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  WIDTH  input word.
- mode  in  1  0 = XOR checksum, 1 = XNOR (inverted) checksum.
- out_valid  out  1  checksum available.
- out_ready  in  1  consumer takes the checksum.
- out_sum  out  WIDTH  frame checksum.
- out_parity  out  1  XOR-reduction of out_sum.
- frame_count  out  8  frames delivered, modulo 256.

Behaviour:
- Reset (async, active-high, takes effect immediately):
  - state=ACCUM, acc=0, word_cnt=0, mode_q=0.
  - out_sum=0, out_parity=0, out_valid=0, frame_count=0.
  - in_ready=1 once reset deasserts.
- Accept = in_valid & in_ready. Output handshake = out_valid & out_ready.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc XOR in_data, computed through WIDTH instances of the NOR-only XOR cell.
  - mode is sampled into mode_q on the accept where word_cnt==0. mode changes mid-frame are ignored.
  - On accept with word_cnt==FRAME_LEN-1:
    - out_sum <= (acc XOR in_data), inverted if mode_q. For FRAME_LEN=1, use the current mode instead of mode_q.
    - out_parity <= XOR-reduction of that value.
    - word_cnt <= 0, state <= HOLD.
  - Otherwise on accept: word_cnt <= word_cnt+1.
  - No accept (in_valid low): all registers hold, so gaps are allowed.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_sum and out_parity stay stable until the output handshake.
  - On handshake: acc <= 0, frame_count <= frame_count+1 (wraps 255->0), state <= ACCUM.
- Latency: out_valid rises on the cycle after the last word is accepted. in_ready returns on the cycle after the output handshake. Throughput is one frame per FRAME_LEN+1 cycles with no stalls.
- Simultaneous events:
  - in_valid in HOLD is ignored (not accepted). The source must hold the word.
  - out_ready in ACCUM has no effect.
- Reset mid-frame discards partial acc and word_cnt. No out_valid pulse is produced.
- out_sum is registered. No combinational path from in_data to the outputs.
- frame_count is unaffected by mode.

Decomposition:
- Shared package holds:
  - ACCUM and HOLD state encodings (1-bit localparams).
  - MODE_XOR=0 and MODE_XNOR=1.
- Sub-module nor_xor_bit: single-bit XOR built only from NOR gates.
  - Internals: two NOR inverters, two cross NORs, a NOR for XNOR, and a final NOR inverter.
  - Instantiated WIDTH times in a generate loop for the accumulate path.
- Checksum inversion and parity reduction stay in the top module.

Test Plan:
- WIDTH=8, FRAME_LEN=4, mode=0, words 0x01,0x02,0x04,0x08 back-to-back -> out_valid on cycle 5, out_sum=0x0F, out_parity=0, frame_count 0->1 after the handshake.
- Same words with mode=1 on the first word, then mode toggled to 0 on word 3 -> out_sum=0xF0, out_parity=0 (mode latched on the first word).
- Backpressure: out_ready held low for 3 cycles in HOLD while in_valid=1 with 0x55 -> in_ready=0, out_sum stable, 0x55 not accepted. It is accepted as word 0 of the next frame after the handshake.
- Reset asserted mid-frame after 2 words, then frame 0xA5,0xA5,0x3C,0x00 -> out_sum=0x3C, out_parity=0, no earlier out_valid.
- WIDTH=1, FRAME_LEN=2, all four {x,y} pairs 00,01,10,11, mode=0 -> out_sum 0,1,1,0 (matches x^y). With mode=1 -> 1,0,0,1.
- 257 frames of all-zero words with in_valid gaps -> frame_count wraps to 1, and out_sum=0x00 in every frame.
